// File: rtl/simd_pkg.sv
// simd_pkg: opcode and sequencer-state enums, instruction field layout and packed instruction word shared by sequencer and PE decoder
package simd_pkg;
  localparam int INS_W = 64;
  localparam int OP_MSB = 63, OP_LSB = 60;
  localparam int DST_MSB = 59, DST_LSB = 49;
  localparam int SRCA_MSB = 48, SRCA_LSB = 38;
  localparam int SRCB_MSB = 37, SRCB_LSB = 27;
  localparam int LANE_MSB = 26, LANE_LSB = 23;
  localparam int RSVD_MSB = 22, RSVD_LSB = 16;
  localparam int CNT_MSB = 15, CNT_LSB = 0;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3,
    OP_MAC = 4'h4, OP_MOV = 4'h5, OP_LOOP = 4'hE, OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_DRAIN, S_DONE} seq_state_e;
  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]     op;
    logic [DST_MSB-DST_LSB:0]   dst;
    logic [SRCA_MSB-SRCA_LSB:0] src_a;
    logic [SRCB_MSB-SRCB_LSB:0] src_b;
    logic [LANE_MSB-LANE_LSB:0] lane_en;
    logic [RSVD_MSB-RSVD_LSB:0] rsvd;
    logic [CNT_MSB-CNT_LSB:0]   count;
  } instr_t;
endpackage

// File: rtl/simd_instr_decode.sv
// simd_instr_decode: splits an instruction word into fields and classifies the opcode (issue/loop/halt/illegal)
module simd_instr_decode import simd_pkg::*; (
  input  logic [INS_W-1:0] word,
  output logic [3:0]       op,
  output logic [10:0]      dst,
  output logic [10:0]      src_a,
  output logic [10:0]      src_b,
  output logic [3:0]       lane_en,
  output logic [15:0]      count,
  output logic             is_issue,
  output logic             is_loop,
  output logic             is_halt,
  output logic             illegal
);
  instr_t f;
  logic unused;
  assign f = word;
  assign unused = ^f.rsvd;
  assign op = f.op;
  assign dst = f.dst;
  assign src_a = f.src_a;
  assign src_b = f.src_b;
  assign lane_en = f.lane_en;
  assign count = f.count;
  assign is_issue = f.op inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_MOV};
  assign is_loop = f.op == OP_LOOP;
  assign is_halt = f.op == OP_HALT;
  assign illegal = !(is_issue || is_loop || is_halt || f.op == OP_NOP);
endmodule

// File: rtl/simd_sequencer.sv
// simd_sequencer: fetch/issue sequencer with one hardware loop; ports: clk/rstn, in_data_valid start, stall, ins_* BRAM read, issue_* handshake, pe_busy, busy/out_data_valid/err_illegal status
module simd_sequencer import simd_pkg::*; #(
  parameter int PE_COUNT = 4,
  parameter int INS_ADDR_WIDTH = 11,
  parameter int INS_WIDTH = 64,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_data_valid,
  input  logic                      stall,
  output logic                      ins_en,
  output logic [INS_ADDR_WIDTH-1:0] ins_addr,
  input  logic [INS_WIDTH-1:0]      ins_rdata,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [3:0]                issue_op,
  output logic [ADDR_WIDTH-1:0]     issue_dst,
  output logic [ADDR_WIDTH-1:0]     issue_src_a,
  output logic [ADDR_WIDTH-1:0]     issue_src_b,
  output logic [PE_COUNT-1:0]       issue_lane_en,
  input  logic                      pe_busy,
  output logic                      busy,
  output logic                      out_data_valid,
  output logic                      err_illegal
);
  seq_state_e state, state_n;
  logic [INS_ADDR_WIDTH-1:0] pc, pc_n;
  logic [15:0] cnt, cnt_n, cnt_eff, count;
  logic [INS_WIDTH-1:0] instr, instr_n;
  logic [10:0] dst, src_a, src_b;
  logic [3:0] lane_en;
  logic loop_active, loop_active_n, err_n, start_q, start;
  logic is_issue, is_loop, is_halt, illegal;
  simd_instr_decode u_dec (
    .word(instr), .op(issue_op), .dst(dst), .src_a(src_a), .src_b(src_b),
    .lane_en(lane_en), .count(count), .is_issue(is_issue), .is_loop(is_loop),
    .is_halt(is_halt), .illegal(illegal)
  );
  assign start = in_data_valid & ~start_q;
  assign cnt_eff = loop_active ? cnt : count;
  assign ins_en = state == S_FETCH && !stall;
  assign ins_addr = pc;
  assign issue_valid = state == S_EXEC && is_issue;
  assign issue_dst = ADDR_WIDTH'(dst);
  assign issue_src_a = ADDR_WIDTH'(src_a);
  assign issue_src_b = ADDR_WIDTH'(src_b);
  assign issue_lane_en = PE_COUNT'(lane_en);
  assign busy = state != S_IDLE && state != S_DONE;
  assign out_data_valid = state == S_DONE;
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    loop_active_n = loop_active;
    err_n = err_illegal;
    instr_n = instr;
    if (!stall)
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            state_n = S_FETCH;
            pc_n = '0;
            loop_active_n = 1'b0;
            err_n = 1'b0;
          end
        S_FETCH: state_n = S_WAIT;
        S_WAIT: begin
          state_n = S_EXEC;
          instr_n = ins_rdata;
        end
        S_EXEC:
          if (is_halt || illegal) begin
            state_n = S_DRAIN;
            err_n = err_illegal | illegal;
          end else if (is_loop && cnt_eff != '0) begin
            cnt_n = cnt_eff - 16'd1;
            loop_active_n = 1'b1;
            pc_n = INS_ADDR_WIDTH'(dst);
            state_n = S_FETCH;
          end else if (!is_issue || issue_ready) begin
            // a sequential step off the top of instruction memory is an error, never a wrap
            loop_active_n = loop_active & ~is_loop;
            state_n = &pc ? S_DRAIN : S_FETCH;
            err_n = err_illegal | (&pc);
            pc_n = &pc ? pc : pc + 1'b1;
          end
        S_DRAIN: state_n = pe_busy ? S_DRAIN : S_DONE;
        default: state_n = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= S_IDLE;
      pc <= '0;
      cnt <= '0;
      loop_active <= 1'b0;
      err_illegal <= 1'b0;
      instr <= '0;
      start_q <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
      loop_active <= loop_active_n;
      err_illegal <= err_n;
      instr <= instr_n;
      start_q <= stall ? start_q : in_data_valid;
    end
endmodule

// File: doc/simd_sequencer.md
# simd_sequencer

Instruction sequencer for the SIMD processor. On a start request, it fetches 64-bit instructions from the instruction BRAM and issues decoded operations to the PE array over a valid/ready handshake. It executes single-level hardware loops and, on HALT, waits for the array to drain before raising `out_data_valid`. It sits between the instruction BRAM read port and the PE array issue port, and it owns the `in_data_valid` / `stall` / `out_data_valid` control triplet.

## Interface
- `PE_COUNT`, default 4, lane count; used for documentation and the lane-enable width.
- `INS_ADDR_WIDTH`, default 11, instruction BRAM address width.
- `INS_WIDTH`, default 64, instruction word width.
- `ADDR_WIDTH`, default 11, data BRAM address width (`$clog2(2048)`).
- `clk`, in, 1, single clock.
- `rstn`, in, 1, asynchronous active-low reset. Asserts asynchronously; one clock, reset is asynchronous and active-low.
- `in_data_valid`, in, 1, start request; acted on at its rising edge only.
- `stall`, in, 1, freeze request. While high, all state, counters and outputs hold.
- `ins_en`, out, 1, instruction BRAM read enable.
- `ins_addr`, out, `INS_ADDR_WIDTH`, instruction fetch address (PC).
- `ins_rdata`, in, `INS_WIDTH`, instruction word; valid one cycle after `ins_en`.
- `issue_valid`, out, 1, operation valid to the PE array.
- `issue_ready`, in, 1, PE array accepts the operation.
- `issue_op`, out, 4, opcode.
- `issue_dst`, out, `ADDR_WIDTH`, destination row.
- `issue_src_a`, out, `ADDR_WIDTH`, first source row.
- `issue_src_b`, out, `ADDR_WIDTH`, second source row.
- `issue_lane_en`, out, `PE_COUNT`, lane enable mask.
- `pe_busy`, in, 1, PE array has operations in flight.
- `busy`, out, 1, high from start until DONE.
- `out_data_valid`, out, 1, program complete. Level signal; held until the next start.
- `err_illegal`, out, 1, sticky error flag; cleared on the next start.

## Operation
- Instruction fields:
  - [63:60] opcode
  - [59:49] dst / loop target
  - [48:38] src_a
  - [37:27] src_b
  - [26:23] lane_en
  - [15:0] loop count
- Opcodes:
  - NOP=0 is consumed without issue.
  - ADD=1, SUB=2, MUL=3, MAC=4, MOV=5 are issued.
  - LOOP=4'hE is handled internally.
  - HALT=4'hF ends the program.
  - Any other opcode is illegal.
- States: IDLE, FETCH, WAIT, EXEC, DRAIN, DONE.
- Transitions:
  - IDLE or DONE to FETCH on start. On entry: PC=0, loop_active=0, `out_data_valid`=0, `err_illegal`=0.
  - FETCH to WAIT: `ins_en`=1, `ins_addr`=PC.
  - WAIT to EXEC: instruction word is registered.
  - EXEC, issued opcode: assert `issue_valid` and hold until `issue_ready`. Then PC+1 and go to FETCH.
  - EXEC, NOP: PC+1, go to FETCH.
  - EXEC, LOOP: if loop_active=0, load cnt=count and set loop_active.
    - If cnt≠0: decrement cnt and set PC=target.
    - Else: clear loop_active and set PC+1.
    - Result: the loop body executes count+1 times. count=0 falls through.
  - EXEC, HALT: go to DRAIN.
  - EXEC, illegal opcode: set `err_illegal`, go to DRAIN.
  - DRAIN to DONE once `pe_busy`=0. `out_data_valid`=1 in DONE.
- Only one loop level exists. Nested LOOP reuses the same counter; this is unsupported and not detected.
- PC wrap: if PC+1 would wrap past 2^`INS_ADDR_WIDTH`-1, set `err_illegal` and go to DRAIN. No wrap to 0 occurs.
- Start (`in_data_valid` rising) while busy is ignored.
- `stall` outranks everything except reset:
  - No state change and no `ins_en` pulse.
  - `issue_valid` and its payload hold stable.
  - A handshake does not complete while `stall`=1, even if `issue_ready`=1.
- Reset values: all outputs 0, state IDLE, PC=0, cnt=0, loop_active=0, edge-detect register 0.

## Timing
- Start edge sampled at cycle 0. FETCH with `ins_en` in cycle 1, WAIT in cycle 2, `issue_valid` in cycle 3.
- Minimum 3 cycles per issued instruction, and 3 cycles per NOP or LOOP. There is no prefetch.
- Issue payload registers change only on handshake or on entry to EXEC.
- HALT decoded in cycle n with `pe_busy`=0: DRAIN in cycle n+1, `out_data_valid`=1 from cycle n+2.
- Reset mid-program: outputs clear asynchronously and the outstanding handshake is abandoned. The PE array must also be reset.

## Structure
- `simd_pkg` holds:
  - `opcode_e`
  - `seq_state_e`
  - field MSB/LSB localparams
  - a packed `instr_t` struct (64 bits)
  
  The PE array decoder shares this package.
- One sub-module, `simd_instr_decode`: combinational field extraction, plus the is_issue/is_loop/is_halt/illegal flags.

## Test plan
- Program {ADD 2,0,1; HALT} with `issue_ready`=1 and `pe_busy`=0: one issue, op=1, dst=2, src_a=0, src_b=1, in cycle 3. `out_data_valid` is high at cycle 8; `busy` is low thereafter.
- Program {MUL 5,3,4; LOOP 0,cnt=2; HALT}: exactly 3 MUL issues, then `out_data_valid`=1 and `err_illegal`=0.
- `issue_ready` low for 4 cycles, with a 2-cycle `stall` during the wait: `issue_valid` and payload stay stable throughout, and there is exactly one handshake.
- Opcode 4'h9 at address 1: `err_illegal`=1, no issue for that word, and DONE is reached. The next start clears `err_illegal`.
- `in_data_valid` held high for 2 cycles, and pulsed again mid-program: exactly one program run.
- `rstn` low during EXEC: all outputs 0 immediately and state IDLE. A new start runs from PC=0.
